// File: rtl/hash_arbiter.sv
// ---------------------------------------------------------------------------
// hash_arbiter
//
// Shares one Jenkins one-at-a-time hash engine between NREQ byte-stream
// requesters. Requesters are granted round-robin; the granted message is fed
// to the engine one byte per cycle, and the finalized 32-bit hash is returned
// tagged with the requester index and a truncation flag.
//
// Optional feature macro: HASH_ARB_LEN_EN
//   defined   -> adds output hash_len (16-bit saturating count of bytes
//                accepted for the message)
//   undefined -> no hash_len port and no byte counter
//
// Modules in this file:
//   jenkins      : single-byte one-at-a-time hash engine (no reset)
//   hash_arbiter : top-level arbiter, FSM and result registers
//
// hash_arbiter ports:
//   CLOCK       in   1       clock, all logic on posedge
//   RESET       in   1       synchronous active-high reset
//   req_valid   in   NREQ    per-requester byte valid
//   req_last    in   NREQ    per-requester final-byte flag
//   req_data    in   8*NREQ  per-requester byte, requester i on [8i+7:8i]
//   req_ready   out  NREQ    one-hot byte accept (granted requester in FEED)
//   hash_valid  out  1       result valid, held until hash_ready
//   hash_ready  in   1       downstream accepts the result
//   hash        out  32      finalized hash
//   hash_id     out  IDW     index of the requester that produced the hash
//   hash_err    out  1       message truncated by a mid-message valid gap
//   hash_len    out  16      (HASH_ARB_LEN_EN only) accepted byte count
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// jenkins
//
// One-at-a-time hash engine. Each cycle with i_sample high mixes i_value into
// the work register. The first idle cycle after a run of samples finalizes
// the work register into o_hash and raises o_complete; o_complete and o_hash
// then hold until the next sample. The second consecutive idle cycle clears
// the work register, so two idle cycles are needed between messages.
//
// Ports:
//   i_clk       in   1   clock
//   i_sample    in   1   mix i_value this cycle
//   i_value     in   8   message byte
//   o_complete  out  1   o_hash holds the finalized hash of the last message
//   o_hash      out  32  finalized hash
// ---------------------------------------------------------------------------
module jenkins (
    input  logic        i_clk,
    input  logic        i_sample,
    input  logic [7:0]  i_value,
    output logic        o_complete,
    output logic [31:0] o_hash
);

    logic [31:0] r_work;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hash;

    logic [31:0] w_add;
    logic [31:0] w_mix;
    logic [31:0] w_step;
    logic [31:0] w_fin1;
    logic [31:0] w_fin2;
    logic [31:0] w_fin;

    // Per-byte mixing step
    always_comb begin
        w_add  = r_work + {24'd0, i_value};
        w_mix  = w_add + (w_add << 10);
        w_step = w_mix ^ (w_mix >> 6);
    end

    // Finalization of the accumulated work register
    always_comb begin
        w_fin1 = r_work + (r_work << 3);
        w_fin2 = w_fin1 ^ (w_fin1 >> 11);
        w_fin  = w_fin2 + (w_fin2 << 15);
    end

    // No reset: the owner guarantees two idle cycles before the first sample.
    always_ff @(posedge i_clk) begin
        if (i_sample) begin
            r_work <= w_step;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_hash <= w_fin;
            r_done <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_work <= '0;
        end
    end

    assign o_complete = r_done;
    assign o_hash     = r_hash;

endmodule

// ---------------------------------------------------------------------------
// hash_arbiter
// ---------------------------------------------------------------------------
module hash_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              hash_valid,
    input  logic              hash_ready,
    output logic [31:0]       hash,
    output logic [IDW-1:0]    hash_id,
    output logic              hash_err
`ifdef HASH_ARB_LEN_EN
    ,
    output logic [15:0]       hash_len
`endif
);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_ARB,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t            r_state;
    logic              r_flush_cnt;
    logic [IDW-1:0]    r_grant;
    logic [IDW-1:0]    r_last_grant;
    logic              r_err;
    logic [NREQ-1:0]   r_req_ready;
    logic              r_hash_valid;
    logic [31:0]       r_hash;
    logic [IDW-1:0]    r_hash_id;
    logic              r_hash_err;
`ifdef HASH_ARB_LEN_EN
    logic [15:0]       r_len;
    logic [15:0]       r_hash_len;
`endif

    logic              w_gvalid;
    logic              w_glast;
    logic [7:0]        w_gdata;
    logic              w_accept;
    logic              w_any;
    logic [IDW-1:0]    w_next;
    int unsigned       w_dist;
    int unsigned       w_best;
    logic              w_eng_complete;
    logic [31:0]       w_eng_hash;

    // Signals of the currently granted requester
    always_comb begin
        w_gvalid = 1'b0;
        w_glast  = 1'b0;
        w_gdata  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_grant == IDW'(i)) begin
                w_gvalid = req_valid[i];
                w_glast  = req_last[i];
                w_gdata  = req_data[8*i +: 8];
            end
        end
    end

    // req_ready is only ever high for the granted requester, so the engine
    // sample is simply the byte handshake.
    assign w_accept = |(req_valid & r_req_ready);

    // Round-robin pick: each valid requester's distance past last_grant;
    // the smallest distance wins (requester last_grant+1 has distance 0).
    always_comb begin
        w_any  = |req_valid;
        w_next = r_last_grant;
        w_best = NREQ;
        w_dist = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - 32'(r_last_grant)) % NREQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_next = IDW'(i);
            end
        end
    end

    jenkins u_engine (
        .i_clk      (CLOCK),
        .i_sample   (w_accept),
        .i_value    (w_gdata),
        .o_complete (w_eng_complete),
        .o_hash     (w_eng_hash)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= S_FLUSH;
            r_flush_cnt  <= 1'b0;
            r_grant      <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_err        <= 1'b0;
            r_req_ready  <= '0;
            r_hash_valid <= 1'b0;
            r_hash       <= '0;
            r_hash_id    <= '0;
            r_hash_err   <= 1'b0;
`ifdef HASH_ARB_LEN_EN
            r_len        <= '0;
            r_hash_len   <= '0;
`endif
        end else begin
            case (r_state)
                S_FLUSH: begin
                    // Two idle cycles clear the engine's work register
                    r_flush_cnt <= 1'b1;
                    if (r_flush_cnt) begin
                        r_flush_cnt <= 1'b0;
                        r_state     <= S_ARB;
                    end
                end

                S_ARB: begin
                    if (w_any) begin
                        r_grant      <= w_next;
                        r_last_grant <= w_next;
                        r_req_ready  <= NREQ'(1) << w_next;
                        r_err        <= 1'b0;
`ifdef HASH_ARB_LEN_EN
                        r_len        <= '0;
`endif
                        r_state      <= S_FEED;
                    end
                end

                S_FEED: begin
                    // A valid gap outranks last; the engine finalizes on the gap
                    if (!w_gvalid) begin
                        r_err       <= 1'b1;
                        r_req_ready <= '0;
                        r_state     <= S_DRAIN;
                    end else if (w_glast) begin
                        r_err       <= 1'b0;
                        r_req_ready <= '0;
                        r_state     <= S_DRAIN;
                    end
`ifdef HASH_ARB_LEN_EN
                    if (w_gvalid && (r_len != '1)) begin
                        r_len <= r_len + 16'd1;
                    end
`endif
                end

                S_DRAIN: begin
                    r_state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    if (w_eng_complete) begin
                        r_hash       <= w_eng_hash;
                        r_hash_id    <= r_grant;
                        r_hash_err   <= r_err;
                        r_hash_valid <= 1'b1;
`ifdef HASH_ARB_LEN_EN
                        r_hash_len   <= r_len;
`endif
                        r_state      <= S_RESULT;
                    end
                end

                S_RESULT: begin
                    if (hash_ready) begin
                        r_hash_valid <= 1'b0;
                        r_state      <= S_ARB;
                    end
                end

                default: begin
                    r_state <= S_FLUSH;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign hash_valid = r_hash_valid;
    assign hash       = r_hash;
    assign hash_id    = r_hash_id;
    assign hash_err   = r_hash_err;
`ifdef HASH_ARB_LEN_EN
    assign hash_len   = r_hash_len;
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hash_arbiter
//
// Scoreboard bench for hash_arbiter. Requester messages are queued per
// requester; a round-robin predictor turns them into an ordered list of
// expected results whose hashes come from a plain one-at-a-time reference
// function. A negedge monitor compares every presented result against the
// scoreboard head, checks result latency and one-hot req_ready.
// ---------------------------------------------------------------------------
module tb_hash_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    typedef struct packed {
        logic [31:0]    h;
        logic [IDW-1:0] id;
        logic           err;
        logic [15:0]    len;
    } exp_t;

    logic              CLOCK;
    logic              RESET;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              hash_valid;
    logic              hash_ready;
    logic [31:0]       hash;
    logic [IDW-1:0]    hash_id;
    logic              hash_err;
`ifdef HASH_ARB_LEN_EN
    logic [15:0]       hash_len;
`endif

    hash_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash       (hash),
        .hash_id    (hash_id),
        .hash_err   (hash_err)
`ifdef HASH_ARB_LEN_EN
        ,
        .hash_len   (hash_len)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Requester byte streams
    logic [7:0]  bq [NREQ][$];
    logic        lq [NREQ][$];
    logic        gq [NREQ][$];
    exp_t        pr [NREQ][$];
    exp_t        sb [$];
    int unsigned latq [$];
    int unsigned gapcnt [NREQ];
    logic [NREQ-1:0] acc;
    int unsigned m_last;
    int          hr_mode;
    int          vectors;
    int          miscompares;
    int unsigned cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference one-at-a-time hash over m[lo..hi-1]
    function automatic logic [31:0] oaat(input logic [7:0] m[$], input int unsigned lo,
                                         input int unsigned hi);
        logic [31:0] h;
        h = 32'd0;
        for (int unsigned j = lo; j < hi; j++) begin
            h = h + 32'(m[j]);
            h = h + (h << 10);
            h = h ^ (h >> 6);
        end
        h = h + (h << 3);
        h = h ^ (h >> 11);
        h = h + (h << 15);
        return h;
    endfunction

    // Queue a message on requester i; gk>0 drops valid for one cycle after
    // gk bytes, which truncates it and makes the rest a fresh message.
    task automatic add_msg(input int unsigned i, input logic [7:0] m[$], input int unsigned gk,
                           input bit kuse, input logic [31:0] kh, input bit no_exp);
        exp_t e;
        int unsigned n;
        n = m.size();
        for (int unsigned j = 0; j < n; j++) begin
            bq[i].push_back(m[j]);
            lq[i].push_back(j == n - 1);
            gq[i].push_back((gk != 0) && (j == gk));
        end
        if (!no_exp) begin
            e.id = IDW'(i);
            if (gk != 0) begin
                e.h = kuse ? kh : oaat(m, 0, gk);
                e.err = 1'b1;
                e.len = 16'(gk);
                pr[i].push_back(e);
                e.h = oaat(m, gk, n);
                e.err = 1'b0;
                e.len = 16'(n - gk);
                pr[i].push_back(e);
            end else begin
                e.h = kuse ? kh : oaat(m, 0, n);
                e.err = 1'b0;
                e.len = 16'(n);
                pr[i].push_back(e);
            end
        end
    endtask

    // Round-robin order among requesters with pending results
    task automatic predict();
        bit more;
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int unsigned k = 1; k <= NREQ; k++) begin
                int unsigned idx;
                idx = (m_last + k) % NREQ;
                if (!more && pr[idx].size() != 0) begin
                    sb.push_back(pr[idx].pop_front());
                    m_last = idx;
                    more = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && bq[i].size() != 0) begin
                void'(bq[i].pop_front());
                void'(lq[i].pop_front());
                void'(gq[i].pop_front());
                gapcnt[i] = 0;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bq[i].size() == 0) begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end else if (gq[i][0] && gapcnt[i] == 0) begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                gapcnt[i]    = 1;
            end else begin
                req_valid[i] = 1'b1;
                req_last[i]  = lq[i][0];
                req_data[8*i +: 8] = bq[i][0];
            end
        end
        case (hr_mode)
            0:       hash_ready = ($urandom_range(0, 9) < 7);
            1:       hash_ready = 1'b1;
            default: hash_ready = 1'b0;
        endcase
        acc = req_valid & req_ready;
    endtask

    function automatic bit busy();
        bit b;
        b = (sb.size() != 0) || hash_valid;
        for (int i = 0; i < NREQ; i++) if (bq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_done(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d results still pending after %0d cycles, required 0",
                     sb.size(), budget);
        end
        repeat (2) tick();
    endtask

    // Monitor
    exp_t m_e;
    logic p_valid, p_ready, p_reset;
    initial begin
        p_valid = 1'b0;
        p_ready = 1'b0;
        p_reset = 1'b1;
        cyc     = 0;
    end

    always @(negedge CLOCK) begin
        cyc++;
        check("req_ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        if (p_valid && !p_ready && !p_reset) check("hash_valid_held", 64'(hash_valid), 64'd1);
        if (hash_valid) begin
            check("req_ready_in_result", 64'(req_ready), 64'd0);
            if (!p_valid) begin
                if (latq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL latency: hash_valid rose at cycle %0d, required no result", cyc);
                end else begin
                    check("latency", 64'(cyc), 64'(latq.pop_front()));
                end
            end
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: hash=0x%0h id=%0d, required no result",
                         hash, hash_id);
            end else begin
                m_e = sb[0];
                check("hash", 64'(hash), 64'(m_e.h));
                check("hash_id", 64'(hash_id), 64'(m_e.id));
                check("hash_err", 64'(hash_err), 64'(m_e.err));
`ifdef HASH_ARB_LEN_EN
                check("hash_len", 64'(hash_len), 64'(m_e.len));
`endif
                if (hash_ready) void'(sb.pop_front());
            end
        end
        // End of a feed: last byte accepted or valid gap; result 3 cycles on
        if (!RESET) begin
            for (int g = 0; g < NREQ; g++) begin
                if (req_ready[g] && (!req_valid[g] || req_last[g])) latq.push_back(cyc + 3);
            end
        end
        p_valid = hash_valid;
        p_ready = hash_ready;
        p_reset = RESET;
    end

    // Stimulus
    logic [7:0] qa [$];
    logic [7:0] qm [$];
    string      fox;

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b1;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        hash_ready  = 1'b0;
        hr_mode     = 1;
        acc         = '0;
        m_last      = NREQ - 1;
        for (int i = 0; i < NREQ; i++) gapcnt[i] = 0;
        qa = '{8'h61};

        repeat (3) tick();
        RESET = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_hash_valid", 64'(hash_valid), 64'd0);
        check("rst_hash", 64'(hash), 64'd0);
        check("rst_hash_id", 64'(hash_id), 64'd0);
        check("rst_hash_err", 64'(hash_err), 64'd0);

        // All requesters with 'a': grants 0,1,2,3,0
        for (int unsigned i = 0; i < NREQ; i++) add_msg(i, qa, 0, 1'b1, 32'hca2e9442, 1'b0);
        add_msg(0, qa, 0, 1'b1, 32'hca2e9442, 1'b0);
        predict();
        wait_done(500);

        // Single 'a' on requester 0
        add_msg(0, qa, 0, 1'b1, 32'hca2e9442, 1'b0);
        predict();
        wait_done(200);

        // Pangram on requester 2
        fox = "The quick brown fox jumps over the lazy dog";
        qm.delete();
        for (int j = 0; j < fox.len(); j++) qm.push_back(fox[j]);
        add_msg(2, qm, 0, 1'b1, 32'h519e91f5, 1'b0);
        predict();
        wait_done(300);

        // Requester 1: 'a', gap, then "bc" as a fresh message
        qm = '{8'h61, 8'h62, 8'h63};
        add_msg(1, qm, 1, 1'b1, 32'hca2e9442, 1'b0);
        predict();
        wait_done(300);

        // Backpressure: hash_ready low for 10 cycles while a result is held
        hr_mode = 2;
        qm = '{8'h10, 8'h20, 8'h30, 8'h40};
        add_msg(3, qm, 0, 1'b0, 32'd0, 1'b0);
        predict();
        for (int n = 0; n < 60 && !hash_valid; n++) tick();
        repeat (10) tick();
        hr_mode = 1;
        wait_done(200);

        // Reset pulsed mid-message: no result, then requester 0 first
        qm.delete();
        for (int j = 0; j < 20; j++) qm.push_back(8'($urandom));
        add_msg(3, qm, 0, 1'b0, 32'd0, 1'b1);
        for (int n = 0; n < 60 && !req_ready[3]; n++) tick();
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_rst_hash_valid", 64'(hash_valid), 64'd0);
        check("mid_rst_hash", 64'(hash), 64'd0);
        check("mid_rst_hash_id", 64'(hash_id), 64'd0);
        check("mid_rst_hash_err", 64'(hash_err), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            bq[i].delete();
            lq[i].delete();
            gq[i].delete();
            gapcnt[i] = 0;
        end
        acc    = '0;
        m_last = NREQ - 1;
        add_msg(1, qa, 0, 1'b1, 32'hca2e9442, 1'b0);
        add_msg(0, qa, 0, 1'b1, 32'hca2e9442, 1'b0);
        predict();
        tick();
        check("flush1_req_ready", 64'(req_ready), 64'd0);
        tick();
        check("flush2_req_ready", 64'(req_ready), 64'd0);
        wait_done(200);

        // Randomized rounds with random backpressure and gaps
        hr_mode = 0;
        for (int r = 0; r < 6; r++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                int unsigned nmsg;
                nmsg = $urandom_range(0, 3);
                for (int unsigned k = 0; k < nmsg; k++) begin
                    int unsigned len;
                    int unsigned gk;
                    len = $urandom_range(1, 12);
                    qm.delete();
                    for (int unsigned j = 0; j < len; j++) qm.push_back(8'($urandom));
                    gk = 0;
                    if (len >= 2 && $urandom_range(0, 3) == 0) gk = $urandom_range(1, len - 1);
                    add_msg(i, qm, gk, 1'b0, 32'd0, 1'b0);
                end
            end
            predict();
            wait_done(5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
